// File: rtl/exme_pkg.sv
// rtl/exme_pkg.sv - shared types and constants for the EX->MEM pipeline register
package exme_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int RADDR_W_DEF    = 5;
    localparam int RSLT_SRC_W_DEF = 2;
    localparam int CNT_W_DEF      = 16;

    typedef struct packed {
        logic                      valid;
        logic                      regWrt;
        logic                      memWrt;
        logic [RSLT_SRC_W_DEF-1:0] rsltSrc;
        logic [RADDR_W_DEF-1:0]    rd;
    } exme_ctrl_t;

    typedef struct packed {
        logic [XLEN_DEF-1:0] aluRslt;
        logic [XLEN_DEF-1:0] wrtD;
        logic [XLEN_DEF-1:0] pc4;
    } exme_data_t;

    localparam exme_ctrl_t EXME_CTRL_BUBBLE = '0;

endpackage

// File: rtl/exme_slot.sv
// rtl/exme_slot.sv - one EX->MEM register slot with flush/stall/async reset
module exme_slot
    import exme_pkg::*;
#(
    parameter type   ctrl_t = exme_ctrl_t,
    parameter type   data_t = exme_data_t,
    parameter ctrl_t BUBBLE = EXME_CTRL_BUBBLE
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  stall,
    input  logic  flush,
    input  ctrl_t ctrl_in,
    input  data_t data_in,
    output ctrl_t ctrl_out,
    output data_t data_out
);

    // Flush only kills control; data fields keep their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_out <= '0;
            data_out <= '0;
        end else if (flush) begin
            ctrl_out <= BUBBLE;
        end else if (!stall) begin
            ctrl_out <= ctrl_in;
            data_out <= data_in;
        end
    end

endmodule

// File: rtl/exme_pipe_reg.sv
// rtl/exme_pipe_reg.sv - DEPTH-deep EX->MEM pipeline register with perf counters
module exme_pipe_reg
    import exme_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int RADDR_W    = RADDR_W_DEF,
    parameter int RSLT_SRC_W = RSLT_SRC_W_DEF,
    parameter int DEPTH      = 1,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  cntClr,
    input  logic                  validE,
    input  logic                  regWrtE,
    input  logic                  memWrtE,
    input  logic [RSLT_SRC_W-1:0] rsltSrcE,
    input  logic [XLEN-1:0]       aluRsltE,
    input  logic [XLEN-1:0]       wrtDE,
    input  logic [XLEN-1:0]       pc4E,
    input  logic [RADDR_W-1:0]    rdE,
    output logic                  validM,
    output logic                  regWrtM,
    output logic                  memWrtM,
    output logic [RSLT_SRC_W-1:0] rsltSrcM,
    output logic [XLEN-1:0]       aluRsltM,
    output logic [XLEN-1:0]       wrtDM,
    output logic [XLEN-1:0]       pc4M,
    output logic [RADDR_W-1:0]    rdM,
    output logic [CNT_W-1:0]      stallCnt,
    output logic [CNT_W-1:0]      bubbleCnt
);

    typedef struct packed {
        logic                  valid;
        logic                  regWrt;
        logic                  memWrt;
        logic [RSLT_SRC_W-1:0] rsltSrc;
        logic [RADDR_W-1:0]    rd;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] aluRslt;
        logic [XLEN-1:0] wrtD;
        logic [XLEN-1:0] pc4;
    } data_t;

    localparam ctrl_t           CTRL_BUBBLE = '0;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    ctrl_t ctrl_e;
    data_t data_e;
    ctrl_t ctrl_q [DEPTH+1];
    data_t data_q [DEPTH+1];

    // An invalid EX op must not write or match forwarding comparators downstream.
    always_comb begin
        ctrl_e         = '0;
        ctrl_e.valid   = validE;
        ctrl_e.rsltSrc = rsltSrcE;
        if (validE) begin
            ctrl_e.regWrt = regWrtE;
            ctrl_e.memWrt = memWrtE;
            ctrl_e.rd     = rdE;
        end
    end

    assign data_e    = {aluRsltE, wrtDE, pc4E};
    assign ctrl_q[0] = ctrl_e;
    assign data_q[0] = data_e;

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        exme_slot #(
            .ctrl_t (ctrl_t),
            .data_t (data_t),
            .BUBBLE (CTRL_BUBBLE)
        ) u_slot (
            .clk      (clk),
            .rst_n    (rst_n),
            .stall    (stall),
            .flush    (flush),
            .ctrl_in  (ctrl_q[k]),
            .data_in  (data_q[k]),
            .ctrl_out (ctrl_q[k+1]),
            .data_out (data_q[k+1])
        );
    end

    assign validM   = ctrl_q[DEPTH].valid;
    assign regWrtM  = ctrl_q[DEPTH].regWrt;
    assign memWrtM  = ctrl_q[DEPTH].memWrt;
    assign rsltSrcM = ctrl_q[DEPTH].rsltSrc;
    assign rdM      = ctrl_q[DEPTH].rd;
    assign aluRsltM = data_q[DEPTH].aluRslt;
    assign wrtDM    = data_q[DEPTH].wrtD;
    assign pc4M     = data_q[DEPTH].pc4;

    // Saturating counters; a clear wins over any increment on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt  <= '0;
            bubbleCnt <= '0;
        end else if (cntClr) begin
            stallCnt  <= '0;
            bubbleCnt <= '0;
        end else begin
            if (stall && !flush && (stallCnt != CNT_MAX)) begin
                stallCnt <= stallCnt + CNT_ONE;
            end
            if (!validM && (bubbleCnt != CNT_MAX)) begin
                bubbleCnt <= bubbleCnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_exme_pipe_reg.sv
// tb/tb_exme_pipe_reg.sv - scoreboard bench for exme_pipe_reg at DEPTH=1 and DEPTH=3
module tb_exme_pipe_reg;

    localparam int XLEN = 32;
    localparam int RW   = 5;
    localparam int SW   = 2;

    logic            clk = 1'b0;
    logic            rst_n, stall, flush, cntClr;
    logic            validE, regWrtE, memWrtE;
    logic [SW-1:0]   rsltSrcE;
    logic [XLEN-1:0] aluRsltE, wrtDE, pc4E;
    logic [RW-1:0]   rdE;

    logic            v1, rw1, mw1, v3, rw3, mw3;
    logic [SW-1:0]   src1, src3;
    logic [XLEN-1:0] alu1, wd1, pc1, alu3, wd3, pc3;
    logic [RW-1:0]   rd1, rd3;
    logic [3:0]      sc1, bc1;
    logic [15:0]     sc3, bc3;

    typedef struct packed {
        logic            v;
        logic            rw;
        logic            mw;
        logic [SW-1:0]   src;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] wd;
        logic [XLEN-1:0] pc;
        logic [RW-1:0]   rd;
    } rec_t;

    rec_t q1[$];
    rec_t q3[$];
    rec_t last1, last3, o1, o3;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   ld = 1'b0;

    always #5 clk = ~clk;

    exme_pipe_reg #(.DEPTH(1), .CNT_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .cntClr(cntClr),
        .validE(validE), .regWrtE(regWrtE), .memWrtE(memWrtE), .rsltSrcE(rsltSrcE),
        .aluRsltE(aluRsltE), .wrtDE(wrtDE), .pc4E(pc4E), .rdE(rdE),
        .validM(v1), .regWrtM(rw1), .memWrtM(mw1), .rsltSrcM(src1),
        .aluRsltM(alu1), .wrtDM(wd1), .pc4M(pc1), .rdM(rd1),
        .stallCnt(sc1), .bubbleCnt(bc1)
    );

    exme_pipe_reg #(.DEPTH(3), .CNT_W(16)) u3 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .cntClr(cntClr),
        .validE(validE), .regWrtE(regWrtE), .memWrtE(memWrtE), .rsltSrcE(rsltSrcE),
        .aluRsltE(aluRsltE), .wrtDE(wrtDE), .pc4E(pc4E), .rdE(rdE),
        .validM(v3), .regWrtM(rw3), .memWrtM(mw3), .rsltSrcM(src3),
        .aluRsltM(alu3), .wrtDM(wd3), .pc4M(pc3), .rdM(rd3),
        .stallCnt(sc3), .bubbleCnt(bc3)
    );

    assign o1 = {v1, rw1, mw1, src1, alu1, wd1, pc1, rd1};
    assign o3 = {v3, rw3, mw3, src3, alu3, wd3, pc3, rd3};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // An edge that loaded (no stall, no flush, out of reset) presents a new slot.
    always @(posedge clk) ld = rst_n && !stall && !flush;

    always @(negedge clk) begin
        if (rst_n && v1) begin
            if (!ld) begin
                check("u1_hold", o1, last1);
            end else if (q1.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL u1_unexpected: got %0h expected none", o1);
            end else begin
                last1 = q1.pop_front();
                check("u1_pop", o1, last1);
            end
        end
        if (rst_n && v3) begin
            if (!ld) begin
                check("u3_hold", o3, last3);
            end else if (q3.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL u3_unexpected: got %0h expected none", o3);
            end else begin
                last3 = q3.pop_front();
                check("u3_pop", o3, last3);
            end
        end
    end

    task automatic drive(input logic v, input logic rw, input logic mw, input logic [SW-1:0] src,
                         input logic [XLEN-1:0] alu, input logic [RW-1:0] rd);
        validE   = v;
        regWrtE  = rw;
        memWrtE  = mw;
        rsltSrcE = src;
        aluRsltE = alu;
        wrtDE    = ~alu;
        pc4E     = alu + 32'd4;
        rdE      = rd;
    endtask

    task automatic step();
        rec_t r;
        if (rst_n && validE && !stall && !flush) begin
            r = {1'b1, regWrtE, memWrtE, rsltSrcE, aluRsltE, wrtDE, pc4E, rdE};
            q1.push_back(r);
            q3.push_back(r);
        end
        @(posedge clk);
        #1;
        if (flush) begin
            q1.delete();
            q3.delete();
        end
    endtask

    initial begin
        rst_n = 1'b1; stall = 1'b0; flush = 1'b0; cntClr = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        check("rst_u1_out", o1, '0);
        check("rst_u3_out", o3, '0);
        check("rst_cnt", {sc1, bc1, sc3, bc3}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        drive(1, 1, 0, 0, 32'h1234, 5); step();
        check("t1_alu", alu1, 32'h1234);
        check("t1_rd", rd1, 5);
        check("t1_rw", rw1, 1);
        check("t1_v", v1, 1);
        drive(1, 0, 1, 1, 32'hDEAD_BEEF, 0); step();
        drive(1, 1, 0, 2, 32'h0000_0001, 31); step();
        drive(0, 1, 1, 3, 32'h5555_AAAA, 9); step();
        drive(1, 1, 1, 3, 32'h8000_0000, 17); step();
        drive(0, 0, 0, 0, 0, 0); repeat (3) step();

        drive(1, 1, 0, 1, 32'hABCD, 12); step();
        check("pre_rst_v", v1, 1);
        drive(0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        q1.delete();
        q3.delete();
        #1;
        check("arst_u1", o1, '0);
        check("arst_u3", o3, '0);
        check("arst_cnt", {sc1, bc1, sc3, bc3}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1, 0, 0, 2, 32'h0F0F_0F0F, 3); step();
        check("lat_u1", v1, 1);
        check("lat_e1", v3, 0);
        drive(0, 0, 0, 0, 0, 0); step();
        check("lat_e2", v3, 0);
        step();
        check("lat_e3", v3, 1);
        repeat (2) step();

        drive(1, 1, 0, 1, 32'h00C0_FFEE, 21); cntClr = 1'b1; step();
        cntClr = 1'b0;
        check("st_e1", v3, 0);
        drive(0, 0, 0, 0, 0, 0); stall = 1'b1; step();
        check("st_e2", v3, 0);
        step();
        check("st_e3", v3, 0);
        stall = 1'b0; step();
        check("st_e4", v3, 0);
        step();
        check("st_e5", v3, 1);
        check("st_rd", rd3, 21);
        check("st_cnt3", sc3, 2);
        check("st_cnt1", sc1, 2);

        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 1, 2'(i), 32'h100 + i, 5'(i + 1)); step();
        end
        drive(0, 0, 0, 0, 0, 0); stall = 1'b1; step(); step();
        stall = 1'b0; repeat (4) step();

        drive(1, 0, 1, 2, 32'hCAFE, 4); step();
        check("fl_pre_mw", mw1, 1);
        drive(1, 0, 1, 1, 32'h7777, 6); stall = 1'b1; flush = 1'b1; step();
        stall = 1'b0; flush = 1'b0;
        check("fl_v", v1, 0);
        check("fl_mw", mw1, 0);
        check("fl_rd", rd1, 0);
        check("fl_src", src1, 0);
        check("fl_alu", alu1, 32'hCAFE);
        check("fl_stall_cnt", sc3, 4);
        drive(0, 0, 0, 0, 0, 0); repeat (3) step();
        check("fl_u3_v", v3, 0);

        drive(0, 1, 0, 0, 32'h9999, 7); cntClr = 1'b1; step();
        cntClr = 1'b0;
        check("inv_rw", rw1, 0);
        check("inv_rd", rd1, 0);
        check("inv_v", v1, 0);
        step(); step();
        check("inv_bc1", bc1, 2);
        check("inv_bc3", bc3, 2);

        drive(0, 0, 0, 0, 0, 0); stall = 1'b1;
        repeat (20) step();
        check("sat_15", sc1, 15);
        step();
        check("sat_hold", sc1, 15);
        check("sat_u3", sc3, 21);
        check("bc_sat1", bc1, 15);
        check("bc_u3", bc3, 23);
        cntClr = 1'b1; step();
        cntClr = 1'b0; stall = 1'b0;
        check("sat_clr1", sc1, 0);
        check("sat_clr3", sc3, 0);
        repeat (2) step();

        check("q1_empty", q1.size(), 0);
        check("q3_empty", q3.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/exme_pipe_reg.md
Name: exme_pipe_reg

Overview:
- Parametrised successor to the EX->MEM pipeline register of the in-order RISC-V core: a DEPTH-deep register chain carrying EX results and control into MEM.
- Adds per-slot valid tracking, stall (hold), flush (bubble injection) and an asynchronous active-low reset.
- Adds saturating stall and bubble performance counters.
- Sits between the ALU/EX stage and the data-memory stage; the hazard unit drives stall/flush.

Parameters:
- XLEN, 32, datapath width of aluRslt, wrtD, pc4.
- RADDR_W, 5, destination register index width.
- RSLT_SRC_W, 2, result-source select width.
- DEPTH, 1, number of chained register slots (>=1); latency in cycles.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold all slots.
- flush  in  1  invalidate all slots (bubble).
- cntClr  in  1  synchronous clear of both counters.
- validE  in  1  EX-stage instruction valid.
- regWrtE  in  1  register write enable.
- memWrtE  in  1  memory write enable.
- rsltSrcE  in  RSLT_SRC_W  result source select.
- aluRsltE  in  XLEN  ALU result.
- wrtDE  in  XLEN  store data.
- pc4E  in  XLEN  PC+4.
- rdE  in  RADDR_W  destination register.
- validM  out  1  output slot valid.
- regWrtM, memWrtM  out  1  gated control.
- rsltSrcM  out  RSLT_SRC_W  result source select.
- aluRsltM, wrtDM, pc4M  out  XLEN  data.
- rdM  out  RADDR_W  destination register.
- stallCnt  out  CNT_W  stall cycles seen.
- bubbleCnt  out  CNT_W  cycles with validM=0.

Behaviour:
- Reset (rst_n=0, asynchronous, immediate): all slots valid=0; every output, including both counters, is 0. Release is sampled synchronously at the next clk edge.
- Priority at each rising edge is flush > stall > load.
- Flush: every slot becomes valid=0, regWrt=0, memWrt=0, rd=0 and rsltSrc=0. XLEN data fields hold their previous value. Flush overrides a simultaneous stall.
- Stall (flush=0): every slot holds all of its fields unchanged.
- Load (stall=0, flush=0): slot0 captures the E inputs and slot k captures slot k-1. Outputs come from slot DEPTH-1.
  - Latency is DEPTH cycles.
  - Throughput is one instruction per cycle.
- Capture gating: when validE=0, slot0 stores regWrt=0, memWrt=0 and rd=0, so a bubble cannot write or cause a false forwarding match. Data fields are still captured.
- Outputs are purely registered; there is no combinational E->M path.
- stallCnt: increments when stall=1 and flush=0.
- bubbleCnt: increments on every edge where validM=0 (the value before the edge).
- Both counters saturate at 2^CNT_W-1 and do not wrap.
- cntClr=1: both counters become 0 on that edge; clear takes priority over increment.
- DEPTH=1 is functionally the legacy register plus the valid/stall/flush/reset behaviour.

Decomposition:
- Package exme_pkg holds:
  - typedef exme_ctrl_t: packed {valid, regWrt, memWrt, rsltSrc, rd}.
  - typedef exme_data_t: packed {aluRslt, wrtD, pc4}.
  - constant EXME_CTRL_BUBBLE (all-zero ctrl).
- Sub-module exme_slot: one register slot.
  - Ports: clk, rst_n, stall, flush, ctrl/data in/out.
  - Instantiated DEPTH times via generate.
- Counters live in the top level.

Test Plan:
- Reset: hold rst_n=0 mid-stream with validM=1 -> all outputs 0 asynchronously, before the next edge; release -> first load appears after DEPTH edges.
- DEPTH=1 streaming: aluRsltE=0x1234, rdE=5, regWrtE=1, validE=1 for 1 cycle -> next edge aluRsltM=0x1234, rdM=5, regWrtM=1, validM=1.
- DEPTH=3 with stall: stall=1 for 2 cycles mid-stream -> outputs frozen for 2 cycles, stallCnt=2, total latency 5 cycles for the stalled instruction.
- Flush with stall: flush=1, stall=1 with memWrtE=1 in flight -> validM=0, memWrtM=0, rdM=0 and aluRsltM unchanged; no store issued.
- Invalid capture: validE=0, regWrtE=1, rdE=7 -> regWrtM=0, rdM=0, validM=0; bubbleCnt increments each such cycle.
- Counter saturation (CNT_W=4): 20 stall cycles -> stallCnt=15 and held; cntClr=1 with stall=1 -> stallCnt=0.
